// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : Synchronises and debounces four active-low buttons and three
//            sensor lines, stretches each press into one low pulse, flags
//            long presses and toggles test mode on a long curar_dec press.
//            Optional auto-repeat in the long state: BTN_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int DEB_CYCLES     = 500000,
    parameter int STRETCH_CYCLES = 15000000,
    parameter int LONG_CYCLES    = 100000000
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int REPEAT_CYCLES  = 12500000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    input  logic [2:0] sns_raw,
    output logic [3:0] btn_o,
    output logic [2:0] sns_o,
    output logic [3:0] btn_long,
    output logic       test_o
);

    localparam int c_deb_w  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_str_w  = $clog2(STRETCH_CYCLES + 1);
    localparam int c_hold_w = $clog2(LONG_CYCLES + 1);
    localparam logic [6:0]          c_idle_lvl = 7'b110_1111;
    localparam logic [c_deb_w-1:0]  c_deb_max  = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_str_w-1:0]  c_str_max  = c_str_w'(STRETCH_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_long_max = c_hold_w'(LONG_CYCLES);
    localparam logic [c_hold_w-1:0] c_long_pre = c_hold_w'(LONG_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam int c_rep_w = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_rep_w-1:0]  c_rep_max  = c_rep_w'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_HELD  = 2'd2,
        S_LONG  = 2'd3
    } state_t;

    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] w_stable;
    logic [3:0] w_long_hit;
    logic [2:0] r_sns;
    logic       r_test;

    // Channel order: [3:0] buttons, [6:4] sensors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= c_idle_lvl;
            r_sync2 <= c_idle_lvl;
        end else begin
            r_sync1 <= {sns_raw, btn_raw};
            r_sync2 <= r_sync1;
        end
    end

    for (genvar c = 0; c < 7; c++) begin : g_deb
        logic [c_deb_w-1:0] r_cnt;
        logic               r_stable;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt    <= '0;
                r_stable <= c_idle_lvl[c];
            end else if (r_sync2[c] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_deb_max) begin
                r_stable <= r_sync2[c];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign w_stable[c] = r_stable;
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        state_t              r_state;
        logic                r_st_d;
        logic                r_pulse_n;
        logic                r_long;
        logic [c_str_w-1:0]  r_str;
        logic [c_hold_w-1:0] r_hold;
        logic                w_st;
        logic                w_fall;
        logic                w_rise;
        logic                w_hit;
        logic                w_rep_fire;
        logic                w_start;
        logic                w_end;

        assign w_st    = w_stable[i];
        assign w_fall  = r_st_d & ~w_st;
        assign w_rise  = ~r_st_d & w_st;
        assign w_hit   = ~w_st & (r_hold == c_long_pre);
        // A start while already low reloads the stretch, so pulses merge
        assign w_start = w_fall | w_rep_fire;
        assign w_end   = ~r_pulse_n & (r_str == '0) & ~w_start;

`ifdef BTN_AUTOREPEAT_EN
        logic [c_rep_w-1:0] r_rep;

        assign w_rep_fire = (r_state == S_LONG) & ~w_rise & (r_rep == c_rep_max);

        always_ff @(posedge clk) begin
            if (rst || r_state != S_LONG || w_rise || w_rep_fire) begin
                r_rep <= '0;
            end else begin
                r_rep <= r_rep + 1'b1;
            end
        end
`else
        assign w_rep_fire = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= S_IDLE;
                r_st_d    <= 1'b1;
                r_pulse_n <= 1'b1;
                r_long    <= 1'b0;
                r_str     <= '0;
                r_hold    <= '0;
            end else begin
                r_st_d <= w_st;
                r_long <= w_hit;

                if (w_st) begin
                    r_hold <= '0;
                end else if (r_hold != c_long_max) begin
                    r_hold <= r_hold + 1'b1;
                end

                if (w_start) begin
                    r_pulse_n <= 1'b0;
                    r_str     <= c_str_max;
                end else if (!r_pulse_n) begin
                    if (r_str == '0) begin
                        r_pulse_n <= 1'b1;
                    end else begin
                        r_str <= r_str - 1'b1;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        if (w_fall) r_state <= S_PULSE;
                    end
                    S_PULSE: begin
                        if (w_hit) begin
                            r_state <= S_LONG;
                        end else if (w_end) begin
                            r_state <= w_st ? S_IDLE : S_HELD;
                        end
                    end
                    S_HELD: begin
                        if (w_hit) begin
                            r_state <= S_LONG;
                        end else if (w_rise) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_LONG: begin
                        // A pulse still stretching at release is let run to length
                        if (w_rise) r_state <= (r_pulse_n | w_end) ? S_IDLE : S_PULSE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign btn_o[i]      = r_pulse_n;
        assign btn_long[i]   = r_long;
        assign w_long_hit[i] = w_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sns  <= c_idle_lvl[6:4];
            r_test <= 1'b0;
        end else begin
            r_sns  <= w_stable[6:4];
            r_test <= r_test ^ w_long_hit[3];
        end
    end

    assign sns_o  = r_sns;
    assign test_o = r_test;

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Brief    : Self-checking bench for btn_conditioner with small timing
//            parameters; directed scenarios plus randomized history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int DEB  = 4;
    localparam int STR  = 6;
    localparam int LNG  = 20;
    localparam int MAXN = 512;
    localparam logic [6:0] IDLE = 7'b110_1111;
`ifdef BTN_AUTOREPEAT_EN
    localparam int REP = 10;
    localparam bit AR  = 1'b1;
`else
    localparam bit AR  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'hF;
    logic [2:0] sns_raw = 3'b110;
    logic [3:0] btn_o;
    logic [2:0] sns_o;
    logic [3:0] btn_long;
    logic       test_o;

    int errors = 0;
    int checks = 0;

    logic [3:0] st_btn [MAXN];
    logic [2:0] st_sns [MAXN];
    logic       st_rst [MAXN];
    logic [3:0] ob_btn [MAXN];
    logic [2:0] ob_sns [MAXN];
    logic [3:0] ob_long[MAXN];
    logic       ob_test[MAXN];
    logic [3:0] ex_btn [MAXN];
    logic [2:0] ex_sns [MAXN];
    logic [3:0] ex_long[MAXN];
    logic       ex_test[MAXN];
    logic [6:0] md_s   [MAXN];

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEB_CYCLES    (DEB),
        .STRETCH_CYCLES(STR),
        .LONG_CYCLES   (LNG)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_CYCLES (REP)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .sns_raw (sns_raw),
        .btn_o   (btn_o),
        .sns_o   (sns_o),
        .btn_long(btn_long),
        .test_o  (test_o)
    );

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 4'hF;
        sns_raw = 3'b110;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_stim(input int n);
        for (int i = 0; i < n; i++) begin
            st_btn[i] = 4'hF;
            st_sns[i] = 3'b110;
            st_rst[i] = 1'b0;
        end
    endtask

    // Index i is the i-th clock edge after reset release
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            rst     = st_rst[i];
            btn_raw = st_btn[i];
            sns_raw = st_sns[i];
            @(posedge clk);
            #1;
            ob_btn[i]  = btn_o;
            ob_sns[i]  = sns_o;
            ob_long[i] = btn_long;
            ob_test[i] = test_o;
        end
        rst = 1'b0;
    endtask

    function automatic logic [6:0] get_raw(input int m);
        if (m < 0) return IDLE;
        return {st_sns[m], st_btn[m]};
    endfunction

    function automatic logic [6:0] sv(input int m);
        if (m < 0) return IDLE;
        return md_s[m];
    endfunction

    function automatic bit is_press(input int p, input int b);
        logic [6:0] a;
        logic [6:0] c;
        a = sv(p - 1);
        c = sv(p - 2);
        return !a[b] && c[b];
    endfunction

    // History-window model: a level flips once DEB consecutive samples,
    // all taken after the previous flip, disagree with it.
    task automatic model_run(input int n);
        int         last_flip [7];
        logic [6:0] prev;
        logic [6:0] rw;
        bit         all_mis;
        bit         pressed;
        bit         held;
        logic       par;
        for (int c = 0; c < 7; c++) last_flip[c] = -1000;
        for (int i = 0; i < n; i++) begin
            prev    = sv(i - 1);
            md_s[i] = prev;
            for (int c = 0; c < 7; c++) begin
                if (i - last_flip[c] >= DEB) begin
                    all_mis = 1'b1;
                    for (int j = 2; j <= DEB + 1; j++) begin
                        rw = get_raw(i - j);
                        if (rw[c] == prev[c]) all_mis = 1'b0;
                    end
                    if (all_mis) begin
                        md_s[i][c]   = ~prev[c];
                        last_flip[c] = i;
                    end
                end
            end
        end
        par = 1'b0;
        for (int i = 0; i < n; i++) begin
            prev      = sv(i - 1);
            ex_sns[i] = prev[6:4];
            for (int b = 0; b < 4; b++) begin
                pressed = 1'b0;
                for (int p = i - STR + 1; p <= i; p++) if (is_press(p, b)) pressed = 1'b1;
                ex_btn[i][b] = ~pressed;
                held = 1'b1;
                for (int m = i - LNG; m <= i - 1; m++) begin
                    rw = sv(m);
                    if (rw[b]) held = 1'b0;
                end
                rw = sv(i - LNG - 1);
                ex_long[i][b] = held & rw[b];
            end
            par        = par ^ ex_long[i][3];
            ex_test[i] = par;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            btn_raw = 4'($urandom);
            sns_raw = 3'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (btn_o !== 4'hF) begin errors++; $display("FAIL reset btn_o: got %b want 1111", btn_o); end
            checks++;
            if (btn_long !== 4'h0) begin errors++; $display("FAIL reset btn_long: got %b want 0000", btn_long); end
            checks++;
            if (test_o !== 1'b0) begin errors++; $display("FAIL reset test_o: got %b want 0", test_o); end
            checks++;
            if (sns_o !== 3'b110) begin errors++; $display("FAIL reset sns_o: got %b want 110", sns_o); end
        end
    endtask

    task automatic test_clean_press();
        logic [3:0] eb;
        do_reset();
        clear_stim(40);
        for (int i = 10; i < 18; i++) st_btn[i] = 4'b1101;
        run(40);
        for (int n = 0; n < 40; n++) begin
            eb = (n >= 16 && n <= 21) ? 4'b1101 : 4'b1111;
            checks++;
            if (ob_btn[n] !== eb) begin errors++; $display("FAIL clean_press btn_o edge %0d: got %b want %b", n, ob_btn[n], eb); end
            checks++;
            if (ob_long[n] !== 4'h0) begin errors++; $display("FAIL clean_press btn_long edge %0d: got %b want 0000", n, ob_long[n]); end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        do_reset();
        clear_stim(30);
        pat = 5'b10101;
        for (int i = 0; i < 5; i++) st_btn[10 + i][0] = pat[4 - i];
        run(30);
        for (int n = 0; n < 30; n++) begin
            checks++;
            if (ob_btn[n] !== 4'hF) begin errors++; $display("FAIL bounce btn_o edge %0d: got %b want 1111", n, ob_btn[n]); end
        end
    endtask

    task automatic test_long_press();
        logic [3:0] eb;
        logic [3:0] el;
        logic       et;
        do_reset();
        clear_stim(120);
        for (int i = 10; i < 40; i++) st_btn[i] = 4'b0111;
        for (int i = 60; i < 90; i++) st_btn[i] = 4'b0111;
        run(120);
        for (int n = 0; n < 120; n++) begin
            eb = ((n >= 16 && n <= 21) || (n >= 66 && n <= 71) ||
                  (AR && ((n >= 45 && n <= 50) || (n >= 95 && n <= 100)))) ? 4'b0111 : 4'b1111;
            el = (n == 35 || n == 85) ? 4'b1000 : 4'b0000;
            et = (n >= 35 && n < 85);
            checks++;
            if (ob_btn[n] !== eb) begin errors++; $display("FAIL long_press btn_o edge %0d: got %b want %b", n, ob_btn[n], eb); end
            checks++;
            if (ob_long[n] !== el) begin errors++; $display("FAIL long_press btn_long edge %0d: got %b want %b", n, ob_long[n], el); end
            checks++;
            if (ob_test[n] !== et) begin errors++; $display("FAIL long_press test_o edge %0d: got %b want %b", n, ob_test[n], et); end
        end
    endtask

    task automatic test_parallel();
        logic [3:0] eb;
        logic [2:0] es;
        logic [3:0] el;
        do_reset();
        clear_stim(40);
        for (int i = 10; i < 40; i++) begin
            st_btn[i] = 4'b0000;
            st_sns[i] = 3'b001;
        end
        run(40);
        for (int n = 0; n < 40; n++) begin
            eb = (n >= 16 && n <= 21) ? 4'b0000 : 4'b1111;
            es = (n >= 16) ? 3'b001 : 3'b110;
            el = (n == 35) ? 4'b1111 : 4'b0000;
            checks++;
            if (ob_btn[n] !== eb) begin errors++; $display("FAIL parallel btn_o edge %0d: got %b want %b", n, ob_btn[n], eb); end
            checks++;
            if (ob_sns[n] !== es) begin errors++; $display("FAIL parallel sns_o edge %0d: got %b want %b", n, ob_sns[n], es); end
            checks++;
            if (ob_long[n] !== el) begin errors++; $display("FAIL parallel btn_long edge %0d: got %b want %b", n, ob_long[n], el); end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] eb;
        logic [3:0] el;
        logic       et;
        do_reset();
        clear_stim(60);
        for (int i = 0; i < 28; i++) st_btn[i] = 4'b0111;
        for (int i = 30; i < 60; i++) st_btn[i] = 4'b1011;
        st_rst[38] = 1'b1;
        st_rst[39] = 1'b1;
        run(60);
        for (int n = 0; n < 60; n++) begin
            eb = 4'b1111;
            if (n >= 6 && n <= 11) eb[3] = 1'b0;
            if ((n >= 36 && n <= 37) || (n >= 46 && n <= 51)) eb[2] = 1'b0;
            el = (n == 25) ? 4'b1000 : 4'b0000;
            et = (n >= 25 && n <= 37);
            checks++;
            if (ob_btn[n] !== eb) begin errors++; $display("FAIL reset_mid btn_o edge %0d: got %b want %b", n, ob_btn[n], eb); end
            checks++;
            if (ob_long[n] !== el) begin errors++; $display("FAIL reset_mid btn_long edge %0d: got %b want %b", n, ob_long[n], el); end
            checks++;
            if (ob_test[n] !== et) begin errors++; $display("FAIL reset_mid test_o edge %0d: got %b want %b", n, ob_test[n], et); end
        end
    endtask

    task automatic test_random();
        int   n;
        int   len;
        int   i;
        logic v;
        n = 400;
        do_reset();
        clear_stim(n);
        for (int c = 0; c < 7; c++) begin
            v = IDLE[c];
            i = 0;
            while (i < n) begin
                if (AR && c < 4) begin
                    len = (v == 1'b0) ? int'($urandom_range(1, 12)) : int'($urandom_range(5, 20));
                end else begin
                    len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 30));
                end
                for (int k = 0; k < len && i < n; k++) begin
                    if (c < 4) st_btn[i][c] = v;
                    else       st_sns[i][c-4] = v;
                    i++;
                end
                v = ~v;
            end
        end
        run(n);
        model_run(n);
        for (int m = 0; m < n; m++) begin
            checks++;
            if (ob_btn[m] !== ex_btn[m]) begin errors++; $display("FAIL random btn_o edge %0d: got %b want %b", m, ob_btn[m], ex_btn[m]); end
            checks++;
            if (ob_sns[m] !== ex_sns[m]) begin errors++; $display("FAIL random sns_o edge %0d: got %b want %b", m, ob_sns[m], ex_sns[m]); end
            checks++;
            if (ob_long[m] !== ex_long[m]) begin errors++; $display("FAIL random btn_long edge %0d: got %b want %b", m, ob_long[m], ex_long[m]); end
            checks++;
            if (ob_test[m] !== ex_test[m]) begin errors++; $display("FAIL random test_o edge %0d: got %b want %b", m, ob_test[m], ex_test[m]); end
        end
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        logic [3:0] eb;
        logic [3:0] el;
        do_reset();
        clear_stim(80);
        for (int i = 10; i < 55; i++) st_btn[i] = 4'b1101;
        run(80);
        for (int n = 0; n < 80; n++) begin
            eb = ((n >= 16 && n <= 21) || (n >= 45 && n <= 50) || (n >= 55 && n <= 60)) ? 4'b1101 : 4'b1111;
            el = (n == 35) ? 4'b0010 : 4'b0000;
            checks++;
            if (ob_btn[n] !== eb) begin errors++; $display("FAIL autorepeat btn_o edge %0d: got %b want %b", n, ob_btn[n], eb); end
            checks++;
            if (ob_long[n] !== el) begin errors++; $display("FAIL autorepeat btn_long edge %0d: got %b want %b", n, ob_long[n], el); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_parallel();
        test_reset_mid();
        test_random();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
